// File: rtl/tlu_record_unpacker_if.sv
// Source-FIFO and readout-stream signals of the trigger-record unpacker.
// master = unpacker side, slave = FIFO/consumer side.
interface tlu_record_unpacker_if;
    logic        FIFO_EMPTY;
    logic [15:0] FIFO_DATA;
    logic        FIFO_READ;
    logic [31:0] DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        RECORD_LAST;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, DATA_READY,
        output FIFO_READ, DATA_OUT, DATA_VALID, RECORD_LAST
    );
    modport slave (
        output FIFO_EMPTY, FIFO_DATA, DATA_READY,
        input  FIFO_READ, DATA_OUT, DATA_VALID, RECORD_LAST
    );
endinterface

// File: rtl/tlu_record_unpacker.sv
// Reassembles 8x16-bit trigger records into 4x32-bit valid/ready words.
// Optional trigger-ID continuity checker enabled by defining TLU_RECORD_ID_CHECK_EN.
module tlu_record_unpacker #(
    parameter int WORDS_PER_RECORD = 8,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    input  logic                     ENABLE,
    tlu_record_unpacker_if.master    bus,
    output logic [31:0]              RECORD_CNT,
    output logic [ERR_CNT_WIDTH-1:0] ID_ERR_CNT,
    output logic                     BUSY
);
    localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_RECORD - 1);

    logic [2:0]  idx;
    logic [15:0] lo_reg;
    logic        out_free;
    logic        rd;
    logic        rd_hi;
    logic        rd_last;

    // Even words only need the lo_reg slot; odd words need DATA_OUT free.
    always_comb begin
        out_free = !bus.DATA_VALID || bus.DATA_READY;
        rd       = BUS_RST_N && !bus.FIFO_EMPTY && ((idx != 3'd0) || ENABLE) &&
                   (!idx[0] || out_free);
        rd_hi    = rd && idx[0];
        rd_last  = rd_hi && (idx == LAST_IDX);
    end

    assign bus.FIFO_READ = rd;
    assign BUSY          = (idx != 3'd0) || bus.DATA_VALID;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            idx    <= 3'd0;
            lo_reg <= 16'h0;
        end else if (rd) begin
            idx <= idx + 3'd1;
            if (!idx[0]) lo_reg <= bus.FIFO_DATA;
        end
    end

    // A new HI word takes priority over clearing on acceptance.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            bus.DATA_OUT    <= 32'h0;
            bus.DATA_VALID  <= 1'b0;
            bus.RECORD_LAST <= 1'b0;
        end else if (rd_hi) begin
            bus.DATA_OUT    <= {bus.FIFO_DATA, lo_reg};
            bus.DATA_VALID  <= 1'b1;
            bus.RECORD_LAST <= (idx == LAST_IDX);
        end else if (bus.DATA_VALID && bus.DATA_READY) begin
            bus.DATA_VALID  <= 1'b0;
            bus.RECORD_LAST <= 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)   RECORD_CNT <= 32'h0;
        else if (rd_last) RECORD_CNT <= RECORD_CNT + 32'd1;
    end

`ifdef TLU_RECORD_ID_CHECK_EN
    logic [31:0] expected_id;
    logic [31:0] rx_id;
    logic        id_seen;

    // The trigger ID low half is the even word still sitting in lo_reg.
    assign rx_id = {bus.FIFO_DATA, lo_reg};

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            expected_id <= 32'h0;
            id_seen     <= 1'b0;
            ID_ERR_CNT  <= '0;
        end else if (rd_last) begin
            expected_id <= rx_id;
            id_seen     <= 1'b1;
            if (id_seen && (rx_id != expected_id + 32'd1) && (ID_ERR_CNT != '1))
                ID_ERR_CNT <= ID_ERR_CNT + ERR_CNT_WIDTH'(1);
        end
    end
`else
    assign ID_ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_tlu_record_unpacker.sv
// Directed + random bench for tlu_record_unpacker with a record-level scoreboard.
module tb_tlu_record_unpacker;
    logic        BUS_CLK   = 1'b0;
    logic        BUS_RST_N = 1'b0;
    logic        ENABLE    = 1'b0;
    logic [31:0] RECORD_CNT;
    logic [15:0] ID_ERR_CNT;
    logic        BUSY;

    tlu_record_unpacker_if bus();

    tlu_record_unpacker #(.WORDS_PER_RECORD(8), .ERR_CNT_WIDTH(16)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .ENABLE(ENABLE), .bus(bus),
        .RECORD_CNT(RECORD_CNT), .ID_ERR_CNT(ID_ERR_CNT), .BUSY(BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Source FIFO model; its pointer is flushed by the same bus reset.
    logic [15:0] src_mem [0:16383];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.FIFO_EMPTY = (rd_ptr == wr_ptr);
    assign bus.FIFO_DATA  = src_mem[rd_ptr[13:0]];
    always @(posedge BUS_CLK or negedge BUS_RST_N)
        if (!BUS_RST_N)         rd_ptr <= wr_ptr;
        else if (bus.FIFO_READ) rd_ptr <= rd_ptr + 1;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    always @(posedge BUS_CLK)
        if (BUS_RST_N && bus.DATA_VALID && bus.DATA_READY)
            got_q.push_back({bus.RECORD_LAST, bus.DATA_OUT});

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int exp_err = 0;
    logic [31:0] prev_id;
    bit have_prev = 0;
    bit stream_on = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err_out();
`ifdef TLU_RECORD_ID_CHECK_EN
        return exp_err;
`else
        return 0;
`endif
    endfunction

    // A record is 128 bits, word i = bits [16i+15:16i]; outputs are its 32-bit slices.
    task automatic push_rec(input logic [127:0] r);
        logic [31:0] id;
        for (int i = 0; i < 8; i++) begin
            src_mem[wr_ptr[13:0]] = r[16*i +: 16];
            wr_ptr++;
        end
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), r[32*k +: 32]});
        id = r[127:96];
        if (have_prev && id != prev_id + 32'd1 && exp_err != 16'hFFFF) exp_err++;
        prev_id   = id;
        have_prev = 1;
        exp_cnt++;
    endtask

    function automatic logic [127:0] mk_rec(input logic [31:0] id);
        return {id, $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_words(input string tag, input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge BUS_CLK);
            c++;
        end
        chk({tag, "_timeout"}, (got_q.size() >= n), 1);
    endtask

    task automatic compare_n(input string tag, input int n);
        chk({tag, "_n"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            if (got_q.size() > 0 && exp_q.size() > 0)
                chk(tag, got_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic model_reset();
        got_q.delete();
        exp_q.delete();
        exp_cnt   = 0;
        exp_err   = 0;
        have_prev = 0;
    endtask

    initial begin
        logic [127:0] seq_rec;
        int base, c;
        logic [31:0] ids [5];
        logic [31:0] id;

        for (int i = 0; i < 8; i++) seq_rec[16*i +: 16] = 16'(i + 1);
        bus.DATA_READY = 1'b0;

        // Reset state; FIFO_READ must stay low even with data and ENABLE
        repeat (2) @(negedge BUS_CLK);
        ENABLE = 1'b1;
        src_mem[wr_ptr[13:0]] = 16'hABCD;
        wr_ptr++;
        #1;
        chk("rst_fifo_read", bus.FIFO_READ, 0);
        chk("rst_data_out", bus.DATA_OUT, 0);
        chk("rst_valid", bus.DATA_VALID, 0);
        chk("rst_last", bus.RECORD_LAST, 0);
        chk("rst_cnt", RECORD_CNT, 0);
        chk("rst_err", ID_ERR_CNT, 0);
        chk("rst_busy", BUSY, 0);
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;

        // Single record, latency and packing
        bus.DATA_READY = 1'b1;
        push_rec(seq_rec);
        @(negedge BUS_CLK);
        chk("lat_valid_lo", bus.DATA_VALID, 0);
        @(negedge BUS_CLK);
        chk("lat_valid_hi", bus.DATA_VALID, 1);
        chk("lat_data", bus.DATA_OUT, 32'h00020001);
        wait_words("single", 4, 50);
        compare_n("single", 4);
        chk("single_cnt", RECORD_CNT, exp_cnt);
        chk("single_busy", BUSY, 0);

        // Backpressure: DATA_OUT holds, exactly one extra even read
        bus.DATA_READY = 1'b0;
        base = rd_ptr;
        push_rec(seq_rec);
        c = 0;
        while (!bus.DATA_VALID && c < 20) begin @(negedge BUS_CLK); c++; end
        chk("bp_valid", bus.DATA_VALID, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge BUS_CLK);
            chk("bp_hold", {bus.RECORD_LAST, bus.DATA_OUT}, {1'b0, 32'h00020001});
        end
        chk("bp_reads", rd_ptr - base, 3);
        chk("bp_head", bus.FIFO_DATA, 16'h0004);
        chk("bp_no_read", bus.FIFO_READ, 0);
        bus.DATA_READY = 1'b1;
        wait_words("bp", 4, 50);
        compare_n("bp", 4);
        chk("bp_cnt", RECORD_CNT, exp_cnt);

        // ENABLE drop at idx 3: record A finishes, record B never starts
        base = rd_ptr;
        push_rec(mk_rec(32'd100));
        push_rec(mk_rec(32'd101));
        c = 0;
        while (rd_ptr - base < 3 && c < 20) begin @(negedge BUS_CLK); c++; end
        ENABLE = 1'b0;
        repeat (20) @(negedge BUS_CLK);
        chk("en_reads", rd_ptr - base, 8);
        chk("en_no_read", bus.FIFO_READ, 0);
        chk("en_busy", BUSY, 0);
        compare_n("en_a", 4);
        chk("en_cnt_a", RECORD_CNT, exp_cnt - 1);
        ENABLE = 1'b1;
        wait_words("en_b", 4, 50);
        compare_n("en_b", 4);
        chk("en_cnt_b", RECORD_CNT, exp_cnt);

        // Asynchronous reset mid-record, away from any clock edge
        base = rd_ptr;
        push_rec(mk_rec(32'd7));
        c = 0;
        while (rd_ptr - base < 5 && c < 20) begin @(negedge BUS_CLK); c++; end
        #2 BUS_RST_N = 1'b0;
        #1;
        chk("arst_valid", bus.DATA_VALID, 0);
        chk("arst_cnt", RECORD_CNT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_read", bus.FIFO_READ, 0);
        model_reset();
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;

        // Trigger-ID continuity
        ids = '{32'd5, 32'd6, 32'd8, 32'hFFFFFFFF, 32'd0};
        for (int i = 0; i < 5; i++) push_rec(mk_rec(ids[i]));
        wait_words("id", 20, 200);
        compare_n("id", 20);
        chk("id_cnt", RECORD_CNT, exp_cnt);
        chk("id_err_model", ID_ERR_CNT, exp_err_out());
`ifdef TLU_RECORD_ID_CHECK_EN
        chk("id_err", ID_ERR_CNT, 2);
`else
        chk("id_err", ID_ERR_CNT, 0);
`endif

        // Random stream with random DATA_READY
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b0;
        model_reset();
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        stream_on = 1;
        fork
            while (stream_on) begin
                @(negedge BUS_CLK);
                bus.DATA_READY = 1'($urandom_range(0, 1));
            end
        join_none
        id = $urandom();
        for (int r = 0; r < 1000; r++) begin
            @(negedge BUS_CLK);
            id = ($urandom_range(0, 19) == 0) ? $urandom() : id + 32'd1;
            push_rec(mk_rec(id));
            repeat ($urandom_range(0, 3)) @(negedge BUS_CLK);
        end
        wait_words("stream", 4000, 20000);
        stream_on = 0;
        @(negedge BUS_CLK);
        bus.DATA_READY = 1'b1;
        compare_n("stream", 4000);
        chk("stream_cnt", RECORD_CNT, 1000);
        chk("stream_err", ID_ERR_CNT, exp_err_out());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlu_record_unpacker.md
# tlu_record_unpacker

Downstream stage of the TLU master core. It drains the 16-bit word stream of the trigger-record FIFO and reassembles each 8-word (128-bit) trigger record. Each record goes out as four 32-bit words on a valid/ready interface towards the readout FIFO. It counts records and, optionally, checks trigger-ID continuity.

## Interface
Parameters:
- WORDS_PER_RECORD, 8, 16-bit words per record; fixed at 8 (the checker relies on it).
- ERR_CNT_WIDTH, 16, width of the saturating ID-error counter.

Ports:
- BUS_CLK  in  1  single clock for the block.
- BUS_RST_N  in  1  reset, asynchronous assert, active-low.
- ENABLE  in  1  allows new records to start draining.
- FIFO_EMPTY  in  1  source empty flag. Low is guaranteed at every mid-record position.
- FIFO_DATA  in  16  source word. Combinationally valid while FIFO_READ is high; sampled on the clock edge.
- FIFO_READ  out  1  pops one source word. Combinational.
- DATA_OUT  out  32  packed output word, registered.
- DATA_VALID  out  1  DATA_OUT holds a word, registered.
- DATA_READY  in  1  consumer accepts DATA_OUT on an edge where DATA_VALID and DATA_READY are both high.
- RECORD_LAST  out  1  high with DATA_VALID on the 4th word of a record.
- RECORD_CNT  out  32  completed records; wraps.
- ID_ERR_CNT  out  ERR_CNT_WIDTH  trigger-ID discontinuities; saturating.
- BUSY  out  1  high while a record is partially drained (word index ≠ 0) or DATA_VALID is high.

## Operation
- Source record word order (index 0..7):
  - 0: {LE1, LE0}
  - 1: {LE3, LE2}
  - 2..5: TIME_STAMP [15:0] .. [63:48]
  - 6..7: TRIG_ID [15:0], [31:16]
- Output words:
  - word0 = {w1, w0}
  - word1 = {w3, w2}
  - word2 = {w5, w4}
  - word3 = {w7, w6}, with RECORD_LAST = 1.
- Counters:
  - word index `idx` (3 bits) counts the current word within the record.
  - phase is the LSB of idx: even = LO, odd = HI.
  - `lo_reg` (16 bits) holds the even word.
- FIFO_READ is high only when all of the following hold:
  - !FIFO_EMPTY;
  - (idx != 0 || ENABLE);
  - (phase == LO || out_free), where out_free = !DATA_VALID || DATA_READY.
- LO read:
  - lo_reg <= FIFO_DATA;
  - idx <= idx + 1.
- HI read:
  - DATA_OUT <= {FIFO_DATA, lo_reg};
  - DATA_VALID <= 1;
  - RECORD_LAST <= (idx == 7);
  - idx <= idx + 1, wrapping 7 to 0.
- DATA_VALID clears on acceptance, unless a HI read loads a new word on the same edge. Back-to-back words then stream at full rate.
- An even word may be read while DATA_OUT is still stalled, so at most one 16-bit word is buffered beyond DATA_OUT.
- ENABLE low:
  - gates only the start of a record (idx == 0);
  - a record in progress always completes, so records are never split.
- RECORD_CNT increments on the HI read at idx == 7.

## Timing
- Reset values (all outputs and state):
  - DATA_OUT = 0, DATA_VALID = 0, RECORD_LAST = 0;
  - RECORD_CNT = 0, ID_ERR_CNT = 0;
  - idx = 0, lo_reg = 0.
  - FIFO_READ is 0 during reset.
- Latency: DATA_VALID rises on the edge that samples the odd word, so the word is visible 1 cycle after that word's FIFO_READ.
- Sustained throughput: one 16-bit word per cycle; one 32-bit output word every 2 cycles when DATA_READY is held high.
- Stall: DATA_VALID high with DATA_READY low holds DATA_OUT and RECORD_LAST stable. FIFO_READ may pulse once more for the next even word, then stays low.
- Reset mid-record:
  - the block returns to idx = 0;
  - the source's word counter must be reset in the same event, or records misalign;
  - the system drives both resets from the bus reset.
- RECORD_CNT wraps 0xFFFFFFFF to 0.

## Configuration
- TLU_RECORD_ID_CHECK_EN defined:
  - on each HI read at idx == 7, the trigger ID is {FIFO_DATA, w6}, with w6 taken from lo_reg.
  - The first record after reset only loads `expected_id` (no compare).
  - Every later record compares the ID against expected_id + 1 (32-bit wrap, so 0xFFFFFFFF to 0 is legal).
  - On mismatch, ID_ERR_CNT increments and saturates at all-ones.
  - expected_id is always reloaded with the received ID.
- Undefined: the checker logic is absent and ID_ERR_CNT is tied to 0.

## Test plan
- Single record:
  - stimulus: words 0x0001 … 0x0008, DATA_READY held high;
  - response: output words 0x00020001, 0x00040003, 0x00060005, 0x00080007;
  - RECORD_LAST high on the last word only; RECORD_CNT = 1.
- Backpressure:
  - stimulus: DATA_READY low for 10 cycles after the first word;
  - response: DATA_OUT holds 0x00020001; exactly one extra FIFO_READ (word 0x0003), then none; all words appear in order once released.
- ENABLE drop:
  - stimulus: ENABLE deasserted at idx = 3;
  - response: the record completes (4 output words); no FIFO_READ at idx = 0 while ENABLE is low.
- Asynchronous reset:
  - stimulus: BUS_RST_N pulsed low mid-record, asynchronous to the clock edge;
  - response: DATA_VALID = 0, RECORD_CNT = 0, idx = 0 immediately.
- ID check (macro defined):
  - stimulus: trigger IDs 5, 6, 8, 0xFFFFFFFF, 0;
  - response: ID_ERR_CNT = 2 (6→8 and 8→0xFFFFFFFF are breaks; 0xFFFFFFFF→0 is not).
  - With the macro undefined: ID_ERR_CNT = 0.
- Stream: 1000 random records with random DATA_READY; the scoreboard matches every word and RECORD_CNT = 1000.
